// File: rtl/level_stepper_pkg.sv
// Shared definitions for the level stepper: direction FSM encoding and the
// constant helpers used to size the position and repeat-timer registers.
package level_stepper_pkg;

  // Per-direction press/repeat state.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RPT  = 2'b10
  } dir_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Ceiling log2, usable in constant expressions.
  function automatic int clog2_int(input int v);
    int r;
    int t;
    r = 0;
    t = v - 1;
    while (t > 0) begin
      r = r + 1;
      t = t >>> 1;
    end
    return r;
  endfunction

  // Timer must be able to hold REPEAT_DELAY.
  function automatic int tmr_w(input int repeat_delay);
    return clog2_int(repeat_delay + 1);
  endfunction

  // Signed width that holds -neg_levels..+pos_levels without wrap.
  function automatic int pos_w(input int neg_levels, input int pos_levels);
    return clog2_int(max_int(neg_levels, pos_levels) + 1) + 1;
  endfunction

endpackage

// File: rtl/level_stepper_if.sv
// Button/position bundle between the button front end (master) and the
// stepper (slave).
// Signalling contract: there is no valid/ready handshake here. up_in, dn_in
// and center_in are levels sampled on every rising clk edge; pos_out, at_max,
// at_min, step_pulse and the two FSM debug states are registered levels valid
// for the whole cycle after the edge that produced them.
interface level_stepper_if
  import level_stepper_pkg::*;
#(
  parameter int POS_W = 3
);

  logic                    up_in;
  logic                    dn_in;
  logic                    center_in;
  logic signed [POS_W-1:0] pos_out;
  logic                    at_max;
  logic                    at_min;
  logic                    step_pulse;
  dir_state_t              up_state;
  dir_state_t              dn_state;

  modport master (
    output up_in, dn_in, center_in,
    input  pos_out, at_max, at_min, step_pulse, up_state, dn_state
  );

  modport slave (
    input  up_in, dn_in, center_in,
    output pos_out, at_max, at_min, step_pulse, up_state, dn_state
  );

endinterface

// File: rtl/level_stepper_press_repeat.sv
// One direction of the stepper: detects a fresh press, then after
// REPEAT_DELAY held cycles auto-steps every REPEAT_RATE cycles until release.
// step is combinational so the position can move on the same edge.
module press_repeat
  import level_stepper_pkg::*;
#(
  parameter int REPEAT_DELAY = 8,
  parameter int REPEAT_RATE  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       x,
  output logic       step,
  output dir_state_t state_dbg
);

  localparam int TMR_W = tmr_w(REPEAT_DELAY);
  localparam logic [TMR_W-1:0] DELAY_T = TMR_W'(REPEAT_DELAY);
  localparam logic [TMR_W-1:0] RATE_T  = TMR_W'(REPEAT_RATE);
  localparam logic [TMR_W-1:0] ONE_T   = TMR_W'(1);

  dir_state_t       state;
  logic             x_prev;
  logic [TMR_W-1:0] timer;
  logic             rise;

  assign rise      = x & ~x_prev;
  assign state_dbg = state;

  // Step request for the current edge, decoded from state and timer.
  always_comb begin
    step = 1'b0;
    case (state)
      IDLE:    step = rise;
      WAIT:    step = x & (timer == DELAY_T);
      RPT:     step = x & (timer == RATE_T);
      default: step = 1'b0;
    endcase
  end

  // Press/repeat FSM with its cycle timer and previous-input register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      timer  <= '0;
      x_prev <= 1'b0;
    end else begin
      x_prev <= x;
      case (state)
        IDLE: begin
          if (rise) begin
            state <= WAIT;
            timer <= ONE_T;
          end
        end
        WAIT: begin
          if (!x) begin
            state <= IDLE;
            timer <= '0;
          end else if (timer == DELAY_T) begin
            state <= RPT;
            timer <= ONE_T;
          end else begin
            timer <= timer + ONE_T;
          end
        end
        RPT: begin
          if (!x) begin
            state <= IDLE;
            timer <= '0;
          end else if (timer == RATE_T) begin
            timer <= ONE_T;
          end else begin
            timer <= timer + ONE_T;
          end
        end
        default: begin
          state <= IDLE;
          timer <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/level_stepper.sv
// Saturating signed position controller driven by up/down buttons with
// hold-to-repeat, a synchronous return-to-centre and saturation flags.
module level_stepper
  import level_stepper_pkg::*;
#(
  parameter int NEG_LEVELS   = 3,
  parameter int POS_LEVELS   = 3,
  parameter int REPEAT_DELAY = 8,
  parameter int REPEAT_RATE  = 4
) (
  input  logic            clk,
  input  logic            reset,
  level_stepper_if.slave  bus
);

  localparam int POS_W = pos_w(NEG_LEVELS, POS_LEVELS);
  localparam logic signed [POS_W-1:0] POS_MAX = POS_W'(POS_LEVELS);
  localparam logic signed [POS_W-1:0] POS_MIN = POS_W'(-NEG_LEVELS);
  localparam logic signed [POS_W-1:0] POS_ONE = POS_W'(1);

  logic                    up_x;
  logic                    dn_x;
  logic                    up_step;
  logic                    dn_step;
  logic signed [POS_W-1:0] pos_q;
  logic signed [POS_W-1:0] pos_nxt;
  logic                    pulse_nxt;
  logic                    at_max_q;
  logic                    at_min_q;
  logic                    pulse_q;

  // Both buttons together count as neither, so the FSMs only ever see one.
  assign up_x = bus.up_in & ~bus.dn_in;
  assign dn_x = bus.dn_in & ~bus.up_in;

  press_repeat #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_RATE  (REPEAT_RATE)
  ) u_up (
    .clk       (clk),
    .reset     (reset),
    .x         (up_x),
    .step      (up_step),
    .state_dbg (bus.up_state)
  );

  press_repeat #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_RATE  (REPEAT_RATE)
  ) u_dn (
    .clk       (clk),
    .reset     (reset),
    .x         (dn_x),
    .step      (dn_step),
    .state_dbg (bus.dn_state)
  );

  // Next position: centre wins, otherwise a step that stays within range.
  always_comb begin
    pos_nxt   = pos_q;
    pulse_nxt = 1'b0;
    if (bus.center_in) begin
      pos_nxt = '0;
    end else if (up_step && (pos_q < POS_MAX)) begin
      pos_nxt   = pos_q + POS_ONE;
      pulse_nxt = 1'b1;
    end else if (dn_step && (pos_q > POS_MIN)) begin
      pos_nxt   = pos_q - POS_ONE;
      pulse_nxt = 1'b1;
    end
  end

  // Position, flags and step pulse all register together off pos_nxt.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos_q    <= '0;
      at_max_q <= 1'b0;
      at_min_q <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      pos_q    <= pos_nxt;
      at_max_q <= (pos_nxt == POS_MAX);
      at_min_q <= (pos_nxt == POS_MIN);
      pulse_q  <= pulse_nxt;
    end
  end

  assign bus.pos_out    = pos_q;
  assign bus.at_max     = at_max_q;
  assign bus.at_min     = at_min_q;
  assign bus.step_pulse = pulse_q;

endmodule

// File: tb/tb_level_stepper.sv
// Directed bench for level_stepper: a default instance (+/-3) and one with
// POS_LEVELS=7 for the long repeat run.
module tb_level_stepper;
  import level_stepper_pkg::*;

  localparam int W_A = pos_w(3, 3);
  localparam int W_B = pos_w(3, 7);

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Clock and reset
  always #5 clk = ~clk;

  level_stepper_if #(.POS_W(W_A)) bus_a ();
  level_stepper_if #(.POS_W(W_B)) bus_b ();

  level_stepper #(.NEG_LEVELS(3), .POS_LEVELS(3)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a.slave)
  );

  level_stepper #(.NEG_LEVELS(3), .POS_LEVELS(7)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus_a.up_in = 1'b0; bus_a.dn_in = 1'b0; bus_a.center_in = 1'b0;
    bus_b.up_in = 1'b0; bus_b.dn_in = 1'b0; bus_b.center_in = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic press_up_a();
    bus_a.up_in = 1'b1;
    tick();
    bus_a.up_in = 1'b0;
    tick();
  endtask

  task automatic press_dn_a();
    bus_a.dn_in = 1'b1;
    tick();
    bus_a.dn_in = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    #2;
    n_tests++;
    if (bus_a.pos_out !== 3'sd0 || bus_a.at_max !== 1'b0 || bus_a.at_min !== 1'b0 ||
        bus_a.step_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got pos=%0d max=%b min=%b pulse=%b want 0 0 0 0",
               bus_a.pos_out, bus_a.at_max, bus_a.at_min, bus_a.step_pulse);
    end
    n_tests++;
    if (bus_a.up_state !== IDLE || bus_a.dn_state !== IDLE) begin
      n_fail++;
      $display("FAIL reset_fsm: got up=%0d dn=%0d want 0 0", bus_a.up_state, bus_a.dn_state);
    end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_single_steps();
    logic signed [W_A-1:0] exp_pos;
    int pulses;
    pulses = 0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      bus_a.up_in = 1'b1;
      tick();
      exp_pos = W_A'(i + 1);
      pulses += int'(bus_a.step_pulse);
      n_tests++;
      if (bus_a.pos_out !== exp_pos || bus_a.step_pulse !== 1'b1 || bus_a.at_max !== (i == 2)) begin
        n_fail++;
        $display("FAIL single_step[%0d]: got pos=%0d pulse=%b max=%b want pos=%0d pulse=1 max=%b",
                 i, bus_a.pos_out, bus_a.step_pulse, bus_a.at_max, exp_pos, (i == 2));
      end
      bus_a.up_in = 1'b0;
      for (int k = 0; k < 4; k++) begin
        tick();
        pulses += int'(bus_a.step_pulse);
      end
    end
    n_tests++;
    if (pulses != 3) begin
      n_fail++;
      $display("FAIL single_pulse_count: got %0d want 3", pulses);
    end
  endtask

  task automatic test_hold_repeat();
    logic [W_B-1:0] exp_q[$];
    logic [W_B-1:0] exp_pos;
    logic           exp_pulse;
    do_reset();
    exp_q = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1,
              4'd2, 4'd2, 4'd2, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3,
              4'd4, 4'd4, 4'd4, 4'd4};
    bus_b.up_in = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      exp_pos   = exp_q.pop_front();
      exp_pulse = (k == 0) || (k == 8) || (k == 12) || (k == 16);
      n_tests++;
      if (bus_b.pos_out !== exp_pos || bus_b.step_pulse !== exp_pulse) begin
        n_fail++;
        $display("FAIL hold_repeat[edge %0d]: got pos=%0d pulse=%b want pos=%0d pulse=%b",
                 k, bus_b.pos_out, bus_b.step_pulse, exp_pos, exp_pulse);
      end
    end
    bus_b.up_in = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    n_tests++;
    if (bus_b.pos_out !== 4'sd4 || bus_b.step_pulse !== 1'b0 || bus_b.up_state !== IDLE) begin
      n_fail++;
      $display("FAIL hold_release: got pos=%0d pulse=%b st=%0d want pos=4 pulse=0 st=0",
               bus_b.pos_out, bus_b.step_pulse, bus_b.up_state);
    end
  endtask

  task automatic test_saturate_min();
    logic exp_pulse;
    do_reset();
    press_dn_a();
    press_dn_a();
    n_tests++;
    if (bus_a.pos_out !== -3'sd2 || bus_a.at_min !== 1'b0) begin
      n_fail++;
      $display("FAIL min_setup: got pos=%0d min=%b want -2 0", bus_a.pos_out, bus_a.at_min);
    end
    bus_a.dn_in = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      exp_pulse = (k == 0);
      n_tests++;
      if (bus_a.pos_out !== -3'sd3 || bus_a.at_min !== 1'b1 || bus_a.step_pulse !== exp_pulse) begin
        n_fail++;
        $display("FAIL min_hold[edge %0d]: got pos=%0d min=%b pulse=%b want -3 1 %b",
                 k, bus_a.pos_out, bus_a.at_min, bus_a.step_pulse, exp_pulse);
      end
    end
    bus_a.dn_in = 1'b0;
    tick();
  endtask

  task automatic test_both_held();
    do_reset();
    bus_a.up_in = 1'b1;
    bus_a.dn_in = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      n_tests++;
      if (bus_a.pos_out !== 3'sd0 || bus_a.step_pulse !== 1'b0) begin
        n_fail++;
        $display("FAIL both_held[%0d]: got pos=%0d pulse=%b want 0 0",
                 k, bus_a.pos_out, bus_a.step_pulse);
      end
    end
    bus_a.dn_in = 1'b0;
    tick();
    n_tests++;
    if (bus_a.pos_out !== 3'sd1 || bus_a.step_pulse !== 1'b1) begin
      n_fail++;
      $display("FAIL both_release: got pos=%0d pulse=%b want 1 1", bus_a.pos_out, bus_a.step_pulse);
    end
    bus_a.up_in = 1'b0;
    tick();
  endtask

  task automatic test_center();
    do_reset();
    press_up_a();
    press_up_a();
    press_up_a();
    n_tests++;
    if (bus_a.pos_out !== 3'sd3 || bus_a.at_max !== 1'b1) begin
      n_fail++;
      $display("FAIL center_setup: got pos=%0d max=%b want 3 1", bus_a.pos_out, bus_a.at_max);
    end
    bus_a.up_in     = 1'b1;
    bus_a.center_in = 1'b1;
    tick();
    n_tests++;
    if (bus_a.pos_out !== 3'sd0 || bus_a.step_pulse !== 1'b0 || bus_a.at_max !== 1'b0) begin
      n_fail++;
      $display("FAIL center: got pos=%0d pulse=%b max=%b want 0 0 0",
               bus_a.pos_out, bus_a.step_pulse, bus_a.at_max);
    end
    bus_a.center_in = 1'b0;
    tick();
    n_tests++;
    if (bus_a.pos_out !== 3'sd0 || bus_a.step_pulse !== 1'b0 || bus_a.up_state !== WAIT) begin
      n_fail++;
      $display("FAIL center_after: got pos=%0d pulse=%b st=%0d want 0 0 1",
               bus_a.pos_out, bus_a.step_pulse, bus_a.up_state);
    end
    bus_a.up_in = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    bus_a.up_in = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    n_tests++;
    if (bus_a.pos_out !== 3'sd2 || bus_a.up_state !== RPT) begin
      n_fail++;
      $display("FAIL mid_hold_setup: got pos=%0d st=%0d want 2 2", bus_a.pos_out, bus_a.up_state);
    end
    reset = 1'b1;
    #1;
    n_tests++;
    if (bus_a.pos_out !== 3'sd0 || bus_a.step_pulse !== 1'b0 || bus_a.up_state !== IDLE) begin
      n_fail++;
      $display("FAIL async_reset: got pos=%0d pulse=%b st=%0d want 0 0 0",
               bus_a.pos_out, bus_a.step_pulse, bus_a.up_state);
    end
    tick();
    tick();
    reset = 1'b0;
    tick();
    n_tests++;
    if (bus_a.pos_out !== 3'sd1 || bus_a.step_pulse !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_step: got pos=%0d pulse=%b want 1 1",
               bus_a.pos_out, bus_a.step_pulse);
    end
    bus_a.up_in = 1'b0;
    tick();
  endtask

  // Watchdog so a stuck run still ends with a report.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_steps();
    test_hold_repeat();
    test_saturate_min();
    test_both_held();
    test_center();
    test_reset_mid_hold();
    // Final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
